// File: rtl/median_pkg.sv
// Shared state encoding, counter widths and default geometry for the median filter controller.
package median_pkg;

  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_WIN        = 5;
  localparam int unsigned DEF_HIST_DEPTH = 11;

  localparam int unsigned X_W  = 10;
  localparam int unsigned Y_W  = 9;
  localparam int unsigned HC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_CLEAR     = 2'd2,
    ST_ACTIVE    = 2'd3
  } state_e;

endpackage

// File: rtl/edge_det.sv
// Edge detector: keeps a registered copy of sig and flags rising/falling transitions against it.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise_c,
  output logic fall_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;
  assign fall_c = ~sig & sig_q;

endmodule

// File: rtl/median_filter_ctrl.sv
// Median filter controller: frame/line sequencing, line-buffer shift control and corner-history tracking.
module median_filter_ctrl
  import median_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned WIN        = DEF_WIN,
  parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            vga_blank_n,
  input  logic            vga_vs,
  output logic            buf_shift_en,
  output logic            ram_clr,
  output logic [X_W-1:0]  pix_x,
  output logic [Y_W-1:0]  pix_y,
  output logic            win_valid,
  output logic            corner_shift,
  output logic [HC_W-1:0] hist_count,
  output logic            median_valid,
  output logic            frame_done,
  output logic            overflow_err
);

  localparam logic [X_W-1:0]  X_LIM   = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]  Y_LIM   = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0]  X_WIN   = X_W'(WIN - 1);
  localparam logic [Y_W-1:0]  Y_WIN   = Y_W'(WIN - 1);
  localparam logic [HC_W-1:0] HC_FULL = HC_W'(HIST_DEPTH);

  logic vs_fall, blank_fall, unused_vs_rise, unused_blank_rise;

  edge_det u_vs_det (
    .clk    (clk),
    .reset  (reset),
    .sig    (vga_vs),
    .rise_c (unused_vs_rise),
    .fall_c (vs_fall)
  );

  edge_det u_blank_det (
    .clk    (clk),
    .reset  (reset),
    .sig    (vga_blank_n),
    .rise_c (unused_blank_rise),
    .fall_c (blank_fall)
  );

  state_e          state_q, state_d;
  logic [X_W-1:0]  x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0]  y_q, y_d, pix_y_q, pix_y_d;
  logic [HC_W-1:0] hist_q, hist_d;
  logic            shift_q, shift_d, clr_q, clr_d, win_q, win_d;
  logic            cs_q, cs_d, fd_q, fd_d, mv_q, mv_d, ovf_q, ovf_d;

  // Next-state and next-output logic; en low overrides everything and zeroes the block.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    hist_d  = hist_q;
    ovf_d   = ovf_q;
    shift_d = 1'b0;
    clr_d   = 1'b0;
    win_d   = 1'b0;
    cs_d    = 1'b0;
    fd_d    = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      pix_x_d = '0;
      pix_y_d = '0;
      hist_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (vs_fall) begin
            state_d = ST_CLEAR;
            clr_d   = 1'b1;
            x_d     = '0;
            y_d     = '0;
            ovf_d   = 1'b0;
          end
        end
        ST_CLEAR: state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (vs_fall) begin
            // Frame boundary wins over a coincident active pixel.
            state_d = ST_CLEAR;
            clr_d   = 1'b1;
            x_d     = '0;
            y_d     = '0;
            ovf_d   = 1'b0;
            fd_d    = 1'b1;
            cs_d    = 1'b1;
            if (hist_q != HC_FULL) hist_d = hist_q + HC_W'(1);
          end else if (vga_blank_n) begin
            shift_d = (x_q < X_LIM) && (y_q < Y_LIM);
            pix_x_d = x_q;
            pix_y_d = y_q;
            win_d   = shift_d && (x_q >= X_WIN) && (y_q >= Y_WIN);
            if (x_q >= X_LIM) ovf_d = 1'b1;
            if (x_q != '1) x_d = x_q + X_W'(1);
          end else begin
            x_d = '0;
            if (blank_fall && (x_q != '0) && (y_q != '1)) y_d = y_q + Y_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    mv_d = (hist_d == HC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      hist_q  <= '0;
      shift_q <= 1'b0;
      clr_q   <= 1'b0;
      win_q   <= 1'b0;
      cs_q    <= 1'b0;
      fd_q    <= 1'b0;
      mv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      hist_q  <= hist_d;
      shift_q <= shift_d;
      clr_q   <= clr_d;
      win_q   <= win_d;
      cs_q    <= cs_d;
      fd_q    <= fd_d;
      mv_q    <= mv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign buf_shift_en = shift_q;
  assign ram_clr      = clr_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign win_valid    = win_q;
  assign corner_shift = cs_q;
  assign hist_count   = hist_q;
  assign median_valid = mv_q;
  assign frame_done   = fd_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Scoreboard bench for median_filter_ctrl: stimulus queues expected output events, a monitor pops and compares them.
module tb_median_filter_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, vga_blank_n, vga_vs;
  logic       buf_shift_en, ram_clr, win_valid, corner_shift, median_valid, frame_done, overflow_err;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [3:0] hist_count;

  median_filter_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .vga_blank_n  (vga_blank_n),
    .vga_vs       (vga_vs),
    .buf_shift_en (buf_shift_en),
    .ram_clr      (ram_clr),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .win_valid    (win_valid),
    .corner_shift (corner_shift),
    .hist_count   (hist_count),
    .median_valid (median_valid),
    .frame_done   (frame_done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       shift;
    logic [9:0] px;
    logic [8:0] py;
    logic       win;
    logic       clr;
    logic       fd;
    logic       cs;
    logic [3:0] hc;
    logic       mv;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_o, mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   win_seen = 0;
  int   frames   = 0;

  function automatic logic [3:0] hist_exp();
    return (frames > 11) ? 4'd11 : 4'(frames);
  endfunction

  // Monitor: every cycle the DUT shifts, clears or strobes is one scoreboard event.
  always @(negedge clk) begin
    if (win_valid === 1'b1) win_seen++;
    if (buf_shift_en === 1'b1 || ram_clr === 1'b1 || frame_done === 1'b1 || corner_shift === 1'b1) begin
      mon_o.shift = buf_shift_en;
      mon_o.px    = buf_shift_en ? pix_x : 10'd0;
      mon_o.py    = buf_shift_en ? pix_y : 9'd0;
      mon_o.win   = win_valid;
      mon_o.clr   = ram_clr;
      mon_o.fd    = frame_done;
      mon_o.cs    = corner_shift;
      mon_o.hc    = hist_count;
      mon_o.mv    = median_valid;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h with nothing expected", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard: got %h expected %h (shift/x/y/win/clr/fd/cs/hc/mv)", mon_o, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, buf_shift_en, ram_clr, pix_x, pix_y, win_valid, corner_shift,
            hist_count, median_valid, frame_done, overflow_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sh, input int x, input int y, input logic clr, input logic fd);
    obs_t e;
    e.shift = sh;
    e.px    = sh ? 10'(x) : 10'd0;
    e.py    = sh ? 9'(y) : 9'd0;
    e.win   = sh && (x >= 4) && (y >= 4);
    e.clr   = clr;
    e.fd    = fd;
    e.cs    = fd;
    e.hc    = hist_exp();
    e.mv    = (hist_exp() == 4'd11);
    exp_q.push_back(e);
  endtask

  task automatic line(input int n, input int y);
    for (int i = 0; i < n; i++) begin
      if (i < 640 && y < 480) push(1'b1, i, y, 1'b0, 1'b0);
      vga_blank_n = 1'b1;
      tick();
    end
    vga_blank_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_start();
    push(1'b0, 0, 0, 1'b1, 1'b0);
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    repeat (2) tick();
  endtask

  task automatic frame_end(input logic with_pixel);
    frames++;
    push(1'b0, 0, 0, 1'b1, 1'b1);
    vga_vs      = 1'b0;
    vga_blank_n = with_pixel;
    tick();
    vga_vs      = 1'b1;
    vga_blank_n = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b0; en = 1'b0; vga_vs = 1'b1; vga_blank_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 32'd0);

    reset = 1'b1; en = 1'b1;
    repeat (2) tick();
    check("wait_sync_outputs", all_outs(), 32'd0);
    frame_start();

    line(700, 0);
    check("overflow_set", 32'(overflow_err), 32'd1);
    w0 = win_seen;
    for (int y = 1; y < 6; y++) line(640, y);
    check("win_count", 32'(win_seen - w0), 32'd1272);
    check("overflow_sticky", 32'(overflow_err), 32'd1);
    frame_end(1'b0);
    check("overflow_cleared", 32'(overflow_err), 32'd0);

    for (int k = 2; k <= 12; k++) begin
      line(8, 0);
      frame_end(k == 2);
    end
    check("hist_saturated", 32'(hist_count), 32'd11);
    check("median_valid_held", 32'(median_valid), 32'd1);

    line(8, 0);
    vga_vs = 1'b0; en = 1'b0;
    tick();
    check("en_off_outputs", all_outs(), 32'd0);
    vga_vs = 1'b1; en = 1'b1; frames = 0;
    repeat (2) tick();
    check("hist_cleared", 32'(hist_count), 32'd0);
    frame_start();

    for (int y = 0; y < 10; y++) line(20, y);
    for (int i = 0; i < 300; i++) begin
      push(1'b1, i, 10, 1'b0, 1'b0);
      vga_blank_n = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();
    check("reset_midframe", all_outs(), 32'd0);
    vga_blank_n = 1'b0; vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    repeat (2) tick();
    check("reset_hold_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    frame_start();
    line(8, 0);

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
